// File: rtl/randomizer_frame_ctrl.sv
// Frame sequencer for the serial randomizer: emits an unrandomized sync marker, then
// FRAME_BYTES payload bytes MSB first, and drives the randomizer's bypass and clear controls.
module randomizer_frame_ctrl #(
    parameter logic [31:0] SYNC_WORD   = 32'h1ACFFC1D,
    parameter int          SYNC_LEN    = 32,
    parameter int          FRAME_BYTES = 1115,
    parameter logic [7:0]  FILL_BYTE   = 8'h00
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic        enable_in,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid_in,
    output logic        byte_ready_out,
    output logic        rand_bit_out,
    output logic        bit_valid_out,
    output logic        rand_bypass_out,
    output logic        rand_clear_out,
    output logic        frame_start_out,
    output logic [15:0] frame_count_out,
    output logic        underrun_out
);

    localparam int MAX_BITS = (SYNC_LEN > 8) ? SYNC_LEN : 8;
    localparam int CNT_W    = $clog2(MAX_BITS);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(7);
    localparam logic [15:0]      BYTE_LAST = 16'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PAYLOAD
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [15:0]      byte_cnt_q, byte_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_empty_q, hold_empty_d;
    logic             frame_done_q, frame_done_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic             underrun_q, underrun_d;
    logic             rand_bit_q, rand_bit_d;
    logic             bit_valid_q, bit_valid_d;
    logic             bypass_q, bypass_d;
    logic             clear_q, clear_d;
    logic             frame_start_q, frame_start_d;

    logic [CNT_W-1:0] sync_idx;
    logic [7:0]       load_byte;

    assign sync_idx = SYNC_LAST - bit_cnt_q;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        shift_d       = shift_q;
        hold_d        = hold_q;
        hold_empty_d  = hold_empty_q;
        underrun_d    = underrun_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q + 16'(frame_done_q);
        rand_bit_d    = 1'b0;
        bit_valid_d   = 1'b0;
        bypass_d      = 1'b0;
        clear_d       = 1'b1;
        frame_start_d = 1'b0;
        load_byte     = FILL_BYTE;

        // Accept only into an empty holding register, so no fall-through during a drain.
        if (byte_valid_in && hold_empty_q) begin
            hold_d       = byte_in;
            hold_empty_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable_in) begin
                    state_d   = ST_SYNC;
                    bit_cnt_d = '0;
                end
            end
            ST_SYNC: begin
                rand_bit_d    = SYNC_WORD[sync_idx];
                bit_valid_d   = 1'b1;
                bypass_d      = 1'b1;
                frame_start_d = (bit_cnt_q == '0);
                if (bit_cnt_q == SYNC_LAST) begin
                    state_d    = ST_PAYLOAD;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_PAYLOAD: begin
                bit_valid_d = 1'b1;
                clear_d     = 1'b0;
                if (bit_cnt_q == '0) begin
                    if (!hold_empty_q) begin
                        load_byte    = hold_q;
                        hold_empty_d = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                    end
                    rand_bit_d = load_byte[7];
                    shift_d    = {load_byte[6:0], 1'b0};
                end else begin
                    rand_bit_d = shift_q[7];
                    shift_d    = {shift_q[6:0], 1'b0};
                end
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    if (byte_cnt_q == BYTE_LAST) begin
                        frame_done_d = 1'b1;
                        byte_cnt_d   = '0;
                        state_d      = enable_in ? ST_SYNC : ST_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 16'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            shift_q       <= '0;
            hold_q        <= '0;
            hold_empty_q  <= 1'b1;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            underrun_q    <= 1'b0;
            rand_bit_q    <= 1'b0;
            bit_valid_q   <= 1'b0;
            bypass_q      <= 1'b0;
            clear_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            shift_q       <= shift_d;
            hold_q        <= hold_d;
            hold_empty_q  <= hold_empty_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            underrun_q    <= underrun_d;
            rand_bit_q    <= rand_bit_d;
            bit_valid_q   <= bit_valid_d;
            bypass_q      <= bypass_d;
            clear_q       <= clear_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign byte_ready_out  = hold_empty_q;
    assign rand_bit_out    = rand_bit_q;
    assign bit_valid_out   = bit_valid_q;
    assign rand_bypass_out = bypass_q;
    assign rand_clear_out  = clear_q;
    assign frame_start_out = frame_start_q;
    assign frame_count_out = frame_count_q;
    assign underrun_out    = underrun_q;

endmodule

// File: doc/randomizer_frame_ctrl.md
Name: randomizer_frame_ctrl

Overview:
- Frame sequencer for the serial randomizer datapath.
- Accepts payload bytes over a valid/ready handshake and emits one bit per clock: an unrandomized sync marker, then FRAME_BYTES payload bytes, MSB first.
- Drives the randomizer's bit input, bypass select and state clear, so every frame's payload starts from an all-zero randomizer state.
- Sits between the byte source (FIFO/packetizer) and the randomizer/RNRZ-L output stage.

Parameters:
- SYNC_WORD, 32'h1ACFFC1D, sync marker, sent MSB first, never randomized.
- SYNC_LEN, 32, number of SYNC_WORD bits sent (the low SYNC_LEN bits); legal range 8..32.
- FRAME_BYTES, 1115, payload bytes per frame; legal range 1..65535.
- FILL_BYTE, 8'h00, byte substituted on underrun.

Ports:
- clock_in  input  1  single clock; all logic on posedge.
- reset_in  input  1  synchronous, active-high reset.
- enable_in  input  1  level; high starts and continues framing.
- byte_in  input  8  payload byte.
- byte_valid_in  input  1  byte_in valid.
- byte_ready_out  output  1  holding register empty; transfer on valid&&ready at a posedge.
- rand_bit_out  output  1  bit presented to the randomizer input.
- bit_valid_out  output  1  rand_bit_out is a live frame bit.
- rand_bypass_out  output  1  1 = send rand_bit_out unrandomized (sync marker).
- rand_clear_out  output  1  1 = randomizer shift register forced to 0 at this edge.
- frame_start_out  output  1  one-cycle pulse coincident with the first sync bit.
- frame_count_out  output  16  completed frames, wraps 65535->0.
- underrun_out  output  1  sticky; set when a fill byte is inserted.

Behaviour:
- All outputs are registered. Every clause below applies only when reset_in is low; reset_in high overrides everything.
- Reset (reset_in high at an edge), including mid-frame:
  - state=IDLE, holding register empty, shifter=0, counters=0.
  - rand_bit_out=0, bit_valid_out=0, rand_bypass_out=0, rand_clear_out=1, frame_start_out=0, byte_ready_out=1, frame_count_out=0, underrun_out=0.
  - No partial frame resumes after reset.
- States: IDLE, SYNC, PAYLOAD.
- IDLE:
  - bit_valid_out=0, rand_bypass_out=0, rand_clear_out=1, rand_bit_out=0.
  - enable_in=1 sampled at edge t -> SYNC; first sync bit appears on the outputs after edge t+1.
- SYNC (SYNC_LEN cycles):
  - bit i of the frame = SYNC_WORD[SYNC_LEN-1-i].
  - bit_valid_out=1, rand_bypass_out=1, rand_clear_out=1 in every SYNC cycle.
  - frame_start_out=1 only on bit 0.
  - On the last sync bit -> PAYLOAD.
- PAYLOAD (FRAME_BYTES*8 cycles):
  - bit_valid_out=1, rand_bypass_out=0, rand_clear_out=0.
  - The shifter loads at each byte boundary (the first payload bit, then every 8 bits) from the holding register if it is full, emptying it.
  - If the holding register is empty at a boundary: load FILL_BYTE and set underrun_out (stays set until reset).
  - Bits go out MSB first.
- End of frame, on the last payload bit:
  - frame_count_out increments, visible on the first cycle after the frame.
  - If enable_in=1 on that edge -> SYNC with no gap cycle (back-to-back frames); else -> IDLE.
- enable_in low mid-frame: the frame completes in full; it is only sampled in IDLE and on the last payload bit.
- Frame period = SYNC_LEN + 8*FRAME_BYTES cycles exactly. Latency from enable_in to the first frame bit = 1 cycle.
- Holding register (1 byte), handshake:
  - byte_ready_out = !full, registered.
  - Accepted in any state, including IDLE and SYNC, so the first byte can be prefetched.
  - A byte accepted at the same edge as a shifter load is held for the next boundary.
  - When full, ready is low even during a draining cycle (no fall-through).
  - byte_valid_in without ready: the byte is not taken, and the source must hold it.
- Counters: bit counter sized for max(SYNC_LEN, 8); byte counter 16 bits; no arithmetic overflow within legal parameter ranges.

Test Plan:
- Reset then IDLE 10 cycles -> bit_valid_out=0, rand_clear_out=1, byte_ready_out=1, frame_count_out=0.
- Defaults with FRAME_BYTES=4; bytes 0xA5,0x3C,0xFF,0x01 preloaded; enable_in pulsed 1 cycle:
  - 32 bits of 0x1ACFFC1D with bypass=1 and clear=1, then 32 payload bits A53CFF01 with bypass=0.
  - frame_start_out on the first bit only; frame_count_out=1; returns to IDLE.
- enable_in held high with bytes streamed -> two frames back-to-back, 64 cycles each, no gap; frame_start_out pulses exactly 64 cycles apart; frame_count_out=2.
- Only 2 of 4 bytes supplied -> bytes 3-4 transmitted as 0x00, underrun_out=1 and stays high through the next good frame.
- reset_in asserted at payload bit 10 -> IDLE on the next cycle, all outputs at reset values; a subsequent enable_in restarts with full sync; the held byte is discarded.
- byte_valid_in held high continuously -> at most one byte accepted per boundary, no byte dropped or duplicated; payload matches the input sequence over 3 frames.
